// File: rtl/gtp_link_seq_if.sv
// rtl/gtp_link_seq_if.sv - link-side and status signal bundle for gtp_link_seq
//
// Purpose: groups the sequencer's non-clock signals into one bundle. The
// sequencer takes the master view. The GTP/Aurora wrapper and the management
// registers take the slave view.
//
// Signals:
//   relink_req    one-cycle pulse that forces a full re-sequence
//   pll_lock      GTP PLL lock, already synchronised to clk
//   lane_up       Aurora lane_up, already synchronised to clk
//   channel_up    Aurora channel_up, already synchronised to clk
//   gtp_reset     GTP reset, active high
//   aurora_reset  Aurora core reset, active high
//   link_ok       high only while the link is up
//   retry_cnt     failed/lost attempts, saturating at 255
//   seq_state     current sequencer state, for the debug registers
interface gtp_link_seq_if;
  logic       relink_req;
  logic       pll_lock;
  logic       lane_up;
  logic       channel_up;
  logic       gtp_reset;
  logic       aurora_reset;
  logic       link_ok;
  logic [7:0] retry_cnt;
  logic [2:0] seq_state;

  modport master (
    input  relink_req, pll_lock, lane_up, channel_up,
    output gtp_reset, aurora_reset, link_ok, retry_cnt, seq_state
  );

  modport slave (
    output relink_req, pll_lock, lane_up, channel_up,
    input  gtp_reset, aurora_reset, link_ok, retry_cnt, seq_state
  );
endinterface

// File: rtl/gtp_link_seq.sv
// rtl/gtp_link_seq.sv - bring-up and recovery sequencer for one GTP + Aurora lane
//
// Purpose: drives the GTP and Aurora resets. It then waits, with timeouts, for
// PLL lock, lane_up and channel_up, and after that monitors the link. The whole
// sequence re-runs when the link is lost or when a relink is requested.
//
// Ports:
//   clk   core clock; all logic runs on the rising edge
//   rst   synchronous, active-high reset
//   lnk   gtp_link_seq_if.master, which carries:
//         relink_req, pll_lock, lane_up, channel_up  (inputs)
//         gtp_reset, aurora_reset, link_ok, retry_cnt[7:0], seq_state[2:0]  (outputs)
//
// Build option: GTP_LINK_SEQ_DEBOUNCE_EN.
//   When defined, loss of link in UP must persist for DEB_CYCLES consecutive
//   cycles before the sequencer gives up on the link.
//   When not defined, a single cycle of loss is enough.
module gtp_link_seq #(
  parameter int RST_CYCLES     = 256,
  parameter int PLL_TO         = 65536,
  parameter int AUR_RST_CYCLES = 128,
  parameter int LANE_TO        = 1048576,
  parameter int CHAN_TO        = 1048576,
  parameter int DEB_CYCLES     = 1024
) (
  input  logic           clk,
  input  logic           rst,
  gtp_link_seq_if.master lnk
);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_PLL  = 3'd1,
    S_AUR_RST   = 3'd2,
    S_WAIT_LANE = 3'd3,
    S_WAIT_CHAN = 3'd4,
    S_UP        = 3'd5
  } state_t;

`ifdef GTP_LINK_SEQ_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif

  // Terminal timer values: the last cycle spent in each timed state.
  localparam logic [20:0] RST_LAST  = 21'(RST_CYCLES - 1);
  localparam logic [20:0] PLL_LAST  = 21'(PLL_TO - 1);
  localparam logic [20:0] AUR_LAST  = 21'(AUR_RST_CYCLES - 1);
  localparam logic [20:0] LANE_LAST = 21'(LANE_TO - 1);
  localparam logic [20:0] CHAN_LAST = 21'(CHAN_TO - 1);
  // UP has no timeout, so the timer counts consecutive loss cycles there.
  // Without debounce the very first loss cycle already reaches this limit.
  localparam logic [20:0] LOSS_LAST = DEB_EN ? 21'(DEB_CYCLES - 1) : 21'd0;

  state_t      state;
  state_t      nxt;
  state_t      nxt_eff;
  logic [20:0] timer;
  logic [7:0]  retry;
  logic        fail;
  logic        fail_eff;
  logic        enter;
  logic        loss;
  logic        gtp_rst_q;
  logic        aur_rst_q;
  logic        link_ok_q;

  assign loss = !(lnk.pll_lock & lnk.lane_up & lnk.channel_up);

  always_comb begin
    nxt  = state;
    fail = 1'b0;
    case (state)
      S_RESET: begin
        if (timer == RST_LAST) nxt = S_WAIT_PLL;
      end
      S_WAIT_PLL: begin
        // Lock is tested before the timeout so success wins a tie.
        if (lnk.pll_lock)            nxt  = S_AUR_RST;
        else if (timer == PLL_LAST)  fail = 1'b1;
      end
      S_AUR_RST: begin
        if (!lnk.pll_lock)           fail = 1'b1;
        else if (timer == AUR_LAST)  nxt  = S_WAIT_LANE;
      end
      S_WAIT_LANE: begin
        if (lnk.lane_up)             nxt  = S_WAIT_CHAN;
        else if (timer == LANE_LAST) fail = 1'b1;
      end
      S_WAIT_CHAN: begin
        if (lnk.lane_up && lnk.channel_up) nxt  = S_UP;
        else if (!lnk.lane_up)             fail = 1'b1;
        else if (timer == CHAN_LAST)       fail = 1'b1;
      end
      S_UP: begin
        if (loss && timer >= LOSS_LAST) fail = 1'b1;
      end
      default: nxt = S_RESET;
    endcase
    if (fail) nxt = S_RESET;

    // A relink request overrides everything and is not counted as a failure.
    nxt_eff  = lnk.relink_req ? S_RESET : nxt;
    fail_eff = fail & !lnk.relink_req;
    // A relink request while already in RESET still restarts the hold timer.
    enter    = lnk.relink_req | (nxt_eff != state);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RESET;
      timer     <= '0;
      retry     <= '0;
      gtp_rst_q <= 1'b1;
      aur_rst_q <= 1'b1;
      link_ok_q <= 1'b0;
    end else begin
      state <= nxt_eff;
      if (enter || (state == S_UP && !loss)) timer <= '0;
      else                                   timer <= timer + 21'd1;
      if (fail_eff && retry != 8'hFF) retry <= retry + 8'd1;
      // Outputs are decoded from the next state, so they move only on transitions.
      gtp_rst_q <= (nxt_eff == S_RESET);
      aur_rst_q <= (nxt_eff inside {S_RESET, S_WAIT_PLL, S_AUR_RST});
      link_ok_q <= (nxt_eff == S_UP);
    end
  end

  assign lnk.gtp_reset    = gtp_rst_q;
  assign lnk.aurora_reset = aur_rst_q;
  assign lnk.link_ok      = link_ok_q;
  assign lnk.retry_cnt    = retry;
  assign lnk.seq_state    = state;

endmodule

// File: tb/tb_gtp_link_seq.sv
// tb/tb_gtp_link_seq.sv - self-checking bench for gtp_link_seq
module tb_gtp_link_seq;
  localparam int RST_CYCLES     = 4;
  localparam int PLL_TO         = 16;
  localparam int AUR_RST_CYCLES = 4;
  localparam int LANE_TO        = 32;
  localparam int CHAN_TO        = 32;
  localparam int DEB_CYCLES     = 8;

`ifdef GTP_LINK_SEQ_DEBOUNCE_EN
  localparam bit DEB_BUILD = 1'b1;
  localparam int LOSS_NEED = DEB_CYCLES;
`else
  localparam bit DEB_BUILD = 1'b0;
  localparam int LOSS_NEED = 1;
`endif

  localparam int P_RESET = 0, P_WAIT_PLL = 1, P_AUR_RST = 2;
  localparam int P_WAIT_LANE = 3, P_WAIT_CHAN = 4, P_UP = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gtp_link_seq_if bus();

  gtp_link_seq #(
    .RST_CYCLES(RST_CYCLES), .PLL_TO(PLL_TO), .AUR_RST_CYCLES(AUR_RST_CYCLES),
    .LANE_TO(LANE_TO), .CHAN_TO(CHAN_TO), .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .lnk(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase, cycles spent in the phase, retries, loss run length.
  int m_ph = P_RESET;
  int m_age = 0;
  int m_retry = 0;
  int m_loss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int  nxt;
    bit  fail;
    bit  up_all;
    int  spent;
    if (rst) begin
      m_ph = P_RESET; m_age = 0; m_retry = 0; m_loss = 0;
      return;
    end
    if (bus.relink_req) begin
      m_ph = P_RESET; m_age = 0; m_loss = 0;
      return;
    end
    nxt    = m_ph;
    fail   = 1'b0;
    spent  = m_age + 1;
    up_all = bus.pll_lock && bus.lane_up && bus.channel_up;
    case (m_ph)
      P_RESET:     if (spent == RST_CYCLES) nxt = P_WAIT_PLL;
      P_WAIT_PLL:  if (bus.pll_lock) nxt = P_AUR_RST; else if (spent == PLL_TO) fail = 1'b1;
      P_AUR_RST:   if (!bus.pll_lock) fail = 1'b1; else if (spent == AUR_RST_CYCLES) nxt = P_WAIT_LANE;
      P_WAIT_LANE: if (bus.lane_up) nxt = P_WAIT_CHAN; else if (spent == LANE_TO) fail = 1'b1;
      P_WAIT_CHAN: begin
        if (bus.lane_up && bus.channel_up) nxt = P_UP;
        else if (!bus.lane_up || spent == CHAN_TO) fail = 1'b1;
      end
      default: begin
        m_loss = up_all ? 0 : m_loss + 1;
        if (m_loss >= LOSS_NEED) fail = 1'b1;
      end
    endcase
    if (fail) begin
      m_retry = (m_retry < 255) ? m_retry + 1 : 255;
      nxt = P_RESET;
    end
    if (nxt != m_ph) begin
      m_ph = nxt; m_age = 0; m_loss = 0;
    end else begin
      m_age++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("seq_state", 32'(bus.seq_state), m_ph);
    check("gtp_reset", 32'(bus.gtp_reset), 32'(m_ph == P_RESET));
    check("aurora_reset", 32'(bus.aurora_reset), 32'(m_ph <= P_AUR_RST));
    check("link_ok", 32'(bus.link_ok), 32'(m_ph == P_UP));
    check("retry_cnt", 32'(bus.retry_cnt), m_retry);
  endtask

  task automatic wait_phase(input int ph, input int budget);
    int n;
    n = 0;
    while (m_ph != ph && n < budget) begin
      tick();
      n++;
    end
    check("wait_phase", 32'(bus.seq_state), ph);
  endtask

  task automatic set_in(input bit p, input bit l, input bit c);
    bus.pll_lock = p; bus.lane_up = l; bus.channel_up = c;
  endtask

  initial begin
    int g_fall, a_fall, l_rise, base, hold;
    bus.relink_req = 1'b0;
    set_in(0, 0, 0);
    rst = 1'b1;
    repeat (3) tick();
    check("rst_gtp", 32'(bus.gtp_reset), 1);
    check("rst_aur", 32'(bus.aurora_reset), 1);
    check("rst_link", 32'(bus.link_ok), 0);

    // Normal bring-up with staggered lock / lane / channel.
    rst = 1'b0;
    g_fall = -1; a_fall = -1; l_rise = -1;
    for (int k = 1; k <= 30; k++) begin
      set_in(k >= 10, k >= 20, k >= 25);
      tick();
      if (g_fall < 0 && bus.gtp_reset == 1'b0) g_fall = k;
      if (a_fall < 0 && bus.aurora_reset == 1'b0) a_fall = k;
      if (l_rise < 0 && bus.link_ok == 1'b1) l_rise = k;
    end
    check("s1_gtp_fall", g_fall, 4);
    check("s1_aur_fall", a_fall, 14);
    check("s1_link_rise", l_rise, 25);
    check("s1_retry", 32'(bus.retry_cnt), 0);

    // Single-cycle channel drop in UP.
    set_in(1, 1, 0);
    tick();
    set_in(1, 1, 1);
    check("s3_blip_link", 32'(bus.link_ok), DEB_BUILD ? 1 : 0);
    check("s3_blip_retry", 32'(bus.retry_cnt), DEB_BUILD ? 0 : 1);
    repeat (20) tick();
    check("s3_back_up", 32'(bus.link_ok), 1);
    base = DEB_BUILD ? 0 : 1;
    set_in(1, 1, 0);
    repeat (DEB_CYCLES) tick();
    check("s3_long_link", 32'(bus.link_ok), 0);
    check("s3_long_retry", 32'(bus.retry_cnt), base + 1);
    set_in(1, 1, 1);
    repeat (20) tick();
    check("s3_relinked", 32'(bus.link_ok), 1);
    base = base + 1;

    // Relink request in UP, then in WAIT_LANE.
    bus.relink_req = 1'b1;
    tick();
    bus.relink_req = 1'b0;
    check("s4_up_state", 32'(bus.seq_state), P_RESET);
    check("s4_up_gtp", 32'(bus.gtp_reset), 1);
    check("s4_up_aur", 32'(bus.aurora_reset), 1);
    check("s4_up_retry", 32'(bus.retry_cnt), base);
    set_in(1, 0, 0);
    wait_phase(P_WAIT_LANE, 50);
    tick();
    bus.relink_req = 1'b1;
    tick();
    bus.relink_req = 1'b0;
    check("s4_wl_state", 32'(bus.seq_state), P_RESET);
    check("s4_wl_gtp", 32'(bus.gtp_reset), 1);
    check("s4_wl_aur", 32'(bus.aurora_reset), 1);
    check("s4_wl_retry", 32'(bus.retry_cnt), base);

    // Reset asserted in the middle of WAIT_LANE.
    wait_phase(P_WAIT_LANE, 50);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s6_state", 32'(bus.seq_state), P_RESET);
    check("s6_gtp", 32'(bus.gtp_reset), 1);
    check("s6_aur", 32'(bus.aurora_reset), 1);
    check("s6_link", 32'(bus.link_ok), 0);
    check("s6_retry", 32'(bus.retry_cnt), 0);

    // lane_up loss in WAIT_CHAN, then channel_up on the timeout cycle.
    set_in(1, 1, 0);
    wait_phase(P_WAIT_CHAN, 50);
    set_in(1, 0, 0);
    tick();
    check("s5_fail_state", 32'(bus.seq_state), P_RESET);
    check("s5_fail_retry", 32'(bus.retry_cnt), 1);
    set_in(1, 1, 0);
    wait_phase(P_WAIT_CHAN, 50);
    repeat (CHAN_TO - 1) tick();
    set_in(1, 1, 1);
    tick();
    check("s5_tie_link", 32'(bus.link_ok), 1);
    check("s5_tie_retry", 32'(bus.retry_cnt), 1);

    // PLL never locks: timeout cadence and saturation.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_in(0, 0, 0);
    repeat (RST_CYCLES + PLL_TO) tick();
    check("s2_first_retry", 32'(bus.retry_cnt), 1);
    check("s2_first_gtp", 32'(bus.gtp_reset), 1);
    repeat (299 * (RST_CYCLES + PLL_TO)) tick();
    check("s2_saturated", 32'(bus.retry_cnt), 255);
    check("s2_sat_state", 32'(bus.seq_state), P_RESET);

    // Randomised regimes of input levels, relink pulses and resets.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hold = 0;
    for (int k = 0; k < 4000; k++) begin
      if (hold == 0) begin
        set_in($urandom_range(0, 9) < 9, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8);
        hold = $urandom_range(1, 40);
      end
      hold--;
      if ($urandom_range(0, 9) == 0) bus.channel_up = ~bus.channel_up;
      bus.relink_req = ($urandom_range(0, 99) == 0);
      rst = ($urandom_range(0, 999) == 0);
      tick();
    end
    bus.relink_req = 1'b0;
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
